// File: rtl/adc_dec_fmt.sv
`timescale 1ns/1ps
// adc_dec_fmt
// Converts signed 16-bit ADC samples into a sign character plus a 5-digit
// packed-BCD magnitude per channel, for a downstream UART formatter.
// The conversion uses one double-dabble iteration per clock.
//
// Ports
//   clk50      : system clock, rising edge
//   reset      : asynchronous, active-high
//   in_valid   : sample present on in_ch / in_data
//   in_ready   : block can accept a sample (IDLE only)
//   in_ch      : channel index 0..7
//   in_data    : signed two's-complement ADC code
//   dec_all    : packed BCD magnitudes, channel n at [18n+17:18n]
//   sig_all    : packed ASCII sign chars, channel n at [8n+7:8n]
//   upd        : one-cycle pulse when a channel slot is written
//   frame_done : one-cycle pulse when the channel 7 slot is written
module adc_dec_fmt #(
  parameter int NCH = 8
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_ch,
  input  logic [15:0]       in_data,
  output logic [18*NCH-1:0] dec_all,
  output logic [8*NCH-1:0]  sig_all,
  output logic              upd,
  output logic              frame_done
);

  typedef enum logic [1:0] {IDLE, SHIFT, STORE} state_t;

  state_t              r_state;
  logic [2:0]          r_ch;
  logic                r_neg;
  logic [15:0]         r_shreg;
  logic [19:0]         r_bcd;
  logic [3:0]          r_cnt;
  logic [18*NCH-1:0]   r_dec;
  logic [8*NCH-1:0]    r_sig;
  logic                r_upd;
  logic                r_frame;

  logic [15:0]         w_mag;
  logic [19:0]         w_adj;
  logic [19:0]         w_bcd_nxt;
  logic                w_unused;

  // 16'h8000 negates to itself, which read as unsigned is 32768.
  assign w_mag = in_data[15] ? (~in_data + 16'd1) : in_data;

  // Add-3 to every digit >= 5, then shift the next magnitude bit in.
  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < 5; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_bcd_nxt = {w_adj[18:0], r_shreg[15]};
  end

  // Top two accumulator bits are always zero for magnitudes <= 32768.
  assign w_unused = &{1'b0, w_adj[19], r_bcd[19:18]};

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ch    <= '0;
      r_neg   <= 1'b0;
      r_shreg <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_dec   <= '0;
      r_sig   <= {NCH{8'h2B}};
      r_upd   <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_upd   <= 1'b0;
      r_frame <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_ch    <= in_ch;
            r_neg   <= in_data[15];
            r_shreg <= w_mag;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd   <= w_bcd_nxt;
          r_shreg <= {r_shreg[14:0], 1'b0};
          r_cnt   <= r_cnt + 4'd1;
          if (r_cnt == 4'd15)
            r_state <= STORE;
        end
        STORE: begin
          r_dec[18*r_ch +: 18] <= r_bcd[17:0];
          r_sig[8*r_ch +: 8]   <= r_neg ? 8'h2D : 8'h2B;
          r_upd                <= 1'b1;
          r_frame              <= (r_ch == 3'd7);
          r_state              <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (r_state == IDLE);
  assign dec_all    = r_dec;
  assign sig_all    = r_sig;
  assign upd        = r_upd;
  assign frame_done = r_frame;

endmodule
